// File: rtl/stage_phv_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_phv_buffer
//  Description : Elastic first-word-fall-through PHV buffer placed between
//                two RMT stages. It gives the upstream stage a registered,
//                margin-based ready signal and passes the control
//                AXI-Stream through a single register stage.
//  Options     : define STAGE_PHV_BUF_STATS_EN to build the overflow drop
//                counter and the occupancy high-water mark. Without it both
//                outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module stage_phv_buffer #(
  parameter int PHV_LEN              = 1124,
  parameter int DEPTH                = 8,
  parameter int AFULL_MARGIN         = 3,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  // PHV path
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              stg_ready,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              phv_out_ready,
  output logic [$clog2(DEPTH):0]            level,
  output logic [31:0]                       drop_cnt,
  output logic [$clog2(DEPTH):0]            hwm,
  // control stream in
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  // control stream out
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_DEPTH_LVL = LVL_W'(DEPTH);
  // Upstream may keep issuing while fewer than this many entries are held,
  // leaving AFULL_MARGIN free slots for PHVs already in flight.
  localparam logic [LVL_W-1:0] C_READY_THR = LVL_W'(DEPTH - AFULL_MARGIN);

  logic [PHV_LEN-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               stg_ready_q;
  logic               push, pop;

  // Pop needs a stored entry, so an empty buffer never bypasses a new PHV.
  // A full buffer still accepts when the head leaves in the same cycle.
  assign pop  = (level_q != '0) & phv_out_ready;
  assign push = phv_in_valid & ((level_q != C_DEPTH_LVL) | pop);

  // Occupancy next state: unchanged when push and pop coincide.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pointers, occupancy and the lagged ready flag.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      stg_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q     <= level_d;
      stg_ready_q <= (level_d < C_READY_THR);
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= phv_in;
  end

  assign phv_out       = mem_q[rd_ptr_q];
  assign phv_out_valid = (level_q != '0);
  assign level         = level_q;
  assign stg_ready     = stg_ready_q;

`ifdef STAGE_PHV_BUF_STATS_EN
  logic [31:0]      drop_cnt_q;
  logic [LVL_W-1:0] hwm_q;
  logic             drop;

  assign drop = phv_in_valid & ~push;

  // Saturating overflow counter and running maximum of the next occupancy.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (level_d > hwm_q) hwm_q <= level_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign hwm      = hwm_q;
`else
  assign drop_cnt = '0;
  assign hwm      = '0;
`endif

  // Control stream: unfiltered one-cycle register copy.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tdata  <= c_s_axis_tdata;
      c_m_axis_tuser  <= c_s_axis_tuser;
      c_m_axis_tkeep  <= c_s_axis_tkeep;
      c_m_axis_tvalid <= c_s_axis_tvalid;
      c_m_axis_tlast  <= c_s_axis_tlast;
    end
  end

endmodule
`default_nettype wire

// File: doc/stage_phv_buffer.md
# stage_phv_buffer

Elastic PHV buffer that sits between consecutive RMT pipeline stages, adding downstream backpressure that the stage datapath itself does not support. It stores up to DEPTH PHVs in a first-word-fall-through FIFO and drives a registered, margin-based `stg_ready` toward the upstream stage so in-flight PHVs are never lost. It forwards the control AXI-Stream through a one-cycle register so per-stage control latency stays uniform.

## Interface
- `PHV_LEN`, default 1124: PHV width in bits.
- `DEPTH`, default 8: FIFO entries; power of 2, minimum 4.
- `AFULL_MARGIN`, default 3: free slots reserved for in-flight PHVs; range 1 to DEPTH-1.
- `C_S_AXIS_DATA_WIDTH`, default 512: control tdata width.
- `C_S_AXIS_TUSER_WIDTH`, default 128: control tuser width.
- `axis_clk`  in  1  clock; the only clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `phv_in`  in  PHV_LEN  PHV from the upstream stage.
- `phv_in_valid`  in  1  PHV strobe; single-cycle and not held.
- `stg_ready`  out  1  registered; 1 means the upstream stage may issue PHVs.
- `phv_out`  out  PHV_LEN  head entry.
- `phv_out_valid`  out  1  FIFO non-empty.
- `phv_out_ready`  in  1  downstream accepts the head.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_cnt`  out  32  PHVs dropped on overflow (see Configuration).
- `hwm`  out  $clog2(DEPTH)+1  high-water mark of `level` (see Configuration).
- `c_s_axis_tdata`, `c_s_axis_tuser`, `c_s_axis_tkeep`, `c_s_axis_tvalid`, `c_s_axis_tlast`  in  widths per parameters  control stream in.
- `c_m_axis_tdata`, `c_m_axis_tuser`, `c_m_axis_tkeep`, `c_m_axis_tvalid`, `c_m_axis_tlast`  out  same widths  control stream out.

## Operation
- Pop: occurs when `phv_out_valid & phv_out_ready`. Read pointer advances.
- Push: occurs when `phv_in_valid & (level < DEPTH | pop)`. `phv_in` is written at the write pointer, which then advances.
- Overflow: `phv_in_valid` with `level == DEPTH` and no pop drops the PHV. Stored contents are unchanged.
- Pointers: `$clog2(DEPTH)` bits, natural wrap. `level` is updated by +1 on push only, -1 on pop only, and is unchanged on both or neither.
- `phv_out` and `phv_out_valid`: combinational from the head entry and `level != 0`. `phv_out` is don't-care when not valid.
- `stg_ready`: registered as `level_next < DEPTH - AFULL_MARGIN`.
- Control path: all five `c_m_*` signals are registered copies of `c_s_*`, with no filtering. `c_m_axis_tvalid` is cleared by reset.
- No state machine beyond FIFO state. Storage is a register array or distributed RAM; no read latency is permitted.

## Timing
- Reset values: `stg_ready`=1, `phv_out_valid`=0, `level`=0, `drop_cnt`=0, `hwm`=0, `c_m_axis_tvalid`=0, `c_m_axis_tlast`=0, `c_m_axis_tdata`/`tuser`/`tkeep`=0. Pointers are cleared.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronous). The first PHV after deassertion is accepted normally.
- Write-to-read latency: a PHV pushed at edge N is visible on `phv_out` with `phv_out_valid`=1 after edge N, provided the FIFO was empty.
- Same-cycle push and pop at `level == DEPTH`: both occur, and `level` stays at DEPTH.
- Same-cycle push and pop at `level == 0`: pop cannot occur, so only the push occurs. There is no bypass.
- `stg_ready` tracks occupancy with one cycle of lag. Upstream must stop issuing within AFULL_MARGIN cycles of `stg_ready` falling; otherwise drops occur.
- Control path latency: exactly 1 cycle.

## Configuration
- `STAGE_PHV_BUF_STATS_EN` defined:
  - `drop_cnt` increments on each dropped PHV and saturates at 0xFFFFFFFF.
  - `hwm` = max(`hwm`, `level_next`) every cycle.
  - Both reset only via `aresetn`.
- Not defined: `drop_cnt` and `hwm` are tied to 0 and no counter logic is synthesised. FIFO behaviour is identical in both builds.

## Test plan
- Single PHV 0xA5.. in, `phv_out_ready`=1 -> `phv_out_valid` high for exactly 1 cycle on the cycle after the push, data matches, `level` returns to 0.
- 8 back-to-back PHVs (values 1..8), `phv_out_ready`=0, DEPTH=8, AFULL_MARGIN=3 -> `stg_ready` falls after the 5th push; `level`=8; drain yields 1..8 in order.
- Full FIFO, 2 more PHVs with `phv_out_ready`=0 -> `level` stays 8, `drop_cnt`=2 with stats enabled (0 without), stored order is unchanged.
- Full FIFO, push and pop in the same cycle -> `level` stays 8, new PHV emerges 8th in order, `drop_cnt` unchanged.
- Control beat tdata=0x1234, tvalid=1, tlast=1 -> identical beat on `c_m_*` one cycle later.
- Assert `aresetn`=0 asynchronously with `level`=5 -> `phv_out_valid`=0, `level`=0, `stg_ready`=1 before the next clock edge.
